// File: rtl/div_rem_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring shift-subtract.
// Optional DIV_EARLY_OUT_EN: divide-by-zero / signed overflow skip the CALC phase.
module div_rem_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [1:0]        op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic              sgn_op, div_zero, ovf;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        b_d       = b_q;
        a_d       = a_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        sgn_op = !op_i[0];
        a_abs  = (sgn_op && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
        b_abs  = (sgn_op && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, b_q};

        // Sign correction, then special cases override the datapath.
        div_zero = (b_q == '0);
        ovf      = !op_q[0] && (a_q == MIN_NEG) && (b_q == XLEN'(1)) && (neg_quo_q ^ neg_rem_q);
        quo_fix  = neg_quo_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        if (div_zero) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else if (ovf) begin
            quo_fix = MIN_NEG;
            rem_fix = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i && !busy_q) begin
                    op_d      = op_i;
                    a_d       = dividend_i;
                    b_d       = b_abs;
                    quo_d     = a_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = sgn_op && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                    neg_rem_d = sgn_op && dividend_i[XLEN-1];
                    state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
                    if ((divisor_i == '0) ||
                        (sgn_op && (dividend_i == MIN_NEG) && (divisor_i == '1))) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                quo_d = {quo_q[XLEN-2:0], !trial[XLEN]};
                rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // valid_o trails DONE by one edge; busy_o covers that pulse.
        valid_d = (state_q == DONE);
        busy_d  = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            b_q       <= '0;
            a_q       <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            b_q       <= b_d;
            a_q       <= a_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_rem_seq.sv
// Scoreboard bench for div_rem_seq: directed vectors, queue-based result/latency checking.
module tb_div_rem_seq;

    localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 34;
`endif
    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        busy_o, valid_o;
    logic [31:0] result_o;

    div_rem_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni && valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, result_o, e.res);
                check({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_busy"}, 32'(busy_o), 32'(1));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'(0));
    endtask

    task automatic expect_res(input string name, input logic [31:0] res, input int lat);
        exp_t e;
        e.name = name;
        e.res  = res;
        e.cyc  = cyc + 1 + lat;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: waits for idle, issues one op, returns once idle again.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat);
        wait_idle();
        op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
        expect_res(name, res, lat);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        int n;
        int guard;
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_result", result_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op("divu_100_7",  DIVU, 32'd100, 32'd7, 32'd14, LAT);
        run_op("remu_100_7",  REMU, 32'd100, 32'd7, 32'd2, LAT);
        run_op("div_m7_2",    DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
        run_op("rem_m7_2",    REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
        run_op("div_7_m2",    DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
        run_op("rem_7_m2",    REM,  32'd7, 32'hFFFF_FFFE, 32'd1, LAT);
        run_op("div_m100_m7", DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, LAT);
        run_op("rem_m100_m7", REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, LAT);
        run_op("divu_big",    DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT);
        run_op("remu_big",    REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, LAT);
        run_op("div_ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
        run_op("rem_ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SP);
        run_op("divu_z",      DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, LAT_SP);
        run_op("remu_z",      REMU, 32'h1234, 32'h0, 32'h1234, LAT_SP);
        run_op("div_m5_z",    DIV,  32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, LAT_SP);
        run_op("rem_m5_z",    REM,  32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, LAT_SP);

        // Start pulses during an active op must be ignored.
        wait_idle();
        op_i = DIVU; dividend_i = 32'd1000; divisor_i = 32'd10; start_i = 1'b1;
        expect_res("busy_ignore", 32'd100, LAT);
        @(negedge clk_i);
        for (int i = 1; i <= 20; i++) begin
            op_i = REMU; dividend_i = 32'(i * 3); divisor_i = 32'd7;
            start_i = 1'b1;
            @(negedge clk_i);
        end
        start_i = 1'b0;
        wait_idle();

        // start_i held high: one accept per idle window.
        op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        n = 0; guard = 0;
        do begin
            if (!busy_o) begin
                expect_res("held_start", 32'd14, LAT);
                n++;
            end
            @(negedge clk_i);
            guard++;
        end while (n < 3 && guard < 400);
        start_i = 1'b0;
        check("held_accepts", 32'(n), 32'd3);
        wait_idle();

        // Async reset in the middle of CALC.
        op_i = DIVU; dividend_i = 32'd12345; divisor_i = 32'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'(0));
        check("midrst_valid", 32'(valid_o), 32'(0));
        check("midrst_result", result_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_op("after_rst", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT);

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        repeat (5) @(negedge clk_i);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
